// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI-flash READ responder.
// Holds the FSM state encoding, the command/field lengths and a byte-lane helper.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    FETCH,
    DATA,
    IGNORE
  } flash_state_t;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam int         CMD_LEN  = 8;
  localparam int         ADDR_LEN = 24;

  // Little-endian byte lane select.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronizer plus registered edge detect for one asynchronous input.
// q, rise and fall all appear 3 clock cycles after the pin changes; no backpressure.
module spi_in_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

  // s3 is the level that the edge pulses describe, so q and the pulses stay aligned.
  assign q = s3;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI-flash READ (0x03) responder: oversampled SPI mode 0, streams memory bytes on MISO.
// Edges act 3 cycles after the pins; 1-cycle memory read latency, one word prefetched ahead.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int MEM_AW   = 22,
  parameter int MIN_HALF = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  logic sck_q, sck_rise, sck_fall;
  logic ss_q, ss_rise, ss_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_in_sync u_sck  (.clock(clock), .reset(reset), .d(spi_sck),  .q(sck_q),  .rise(sck_rise),  .fall(sck_fall));
  spi_in_sync u_ss   (.clock(clock), .reset(reset), .d(spi_ss_n), .q(ss_q),   .rise(ss_rise),   .fall(ss_fall));
  spi_in_sync u_mosi (.clock(clock), .reset(reset), .d(spi_mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

  flash_state_t      state, state_nxt;
  logic [7:0]        cmd, cmd_shift;
  logic [ADDR_W-1:0] addr, addr_shift;
  logic [31:0]       word, nxt_word;
  logic [7:0]        shreg;
  logic [4:0]        bit_cnt;
  logic [1:0]        byte_ptr;
  logic              skip_fall;
  logic              rd_vld;
  logic [7:0]        half_cnt;
  logic              edge_seen;

  logic unused_sync;
  assign unused_sync = ^{sck_q, ss_rise, mosi_rise, mosi_fall, cmd[7], addr[ADDR_W-1]};

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cmd_shift  = {cmd[6:0], mosi_q};
    addr_shift = {addr[ADDR_W-2:0], mosi_q};
    case (state)
      IDLE:   if (ss_fall) state_nxt = CMD;
      CMD:    if (sck_rise && bit_cnt == 5'(CMD_LEN - 1))
                state_nxt = (cmd_shift == CMD_READ) ? ADDR : IGNORE;
      ADDR:   if (sck_rise && bit_cnt == 5'(ADDR_LEN - 1)) state_nxt = FETCH;
      FETCH:  if (rd_vld) state_nxt = DATA;
      default: state_nxt = state;
    endcase
    // SS high overrides everything, including a coincident SCK rise.
    if (ss_q) state_nxt = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd       <= '0;
      addr      <= '0;
      word      <= '0;
      nxt_word  <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      byte_ptr  <= '0;
      skip_fall <= 1'b0;
      rd_vld    <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      cmd_err   <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      cmd_err <= 1'b0;
      rd_vld  <= mem_en;
      if (ss_q) begin
        bit_cnt   <= '0;
        skip_fall <= 1'b0;
      end else begin
        case (state)
          IDLE: if (ss_fall) bit_cnt <= '0;
          CMD: if (sck_rise) begin
            cmd     <= cmd_shift;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'(CMD_LEN - 1)) begin
              bit_cnt <= '0;
              cmd_err <= (cmd_shift != CMD_READ);
            end
          end
          ADDR: if (sck_rise) begin
            addr    <= addr_shift;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'(ADDR_LEN - 1)) begin
              bit_cnt  <= '0;
              mem_en   <= 1'b1;
              mem_addr <= addr_shift[ADDR_W-1:2];
              byte_ptr <= addr_shift[1:0];
            end
          end
          FETCH: if (rd_vld) begin
            word      <= mem_rdata;
            shreg     <= word_byte(mem_rdata, byte_ptr);
            mem_en    <= 1'b1;
            mem_addr  <= mem_addr + MEM_AW'(1);
            skip_fall <= 1'b1;
          end
          DATA: begin
            if (rd_vld) nxt_word <= mem_rdata;
            // The first fall only ends the last address bit; shreg is already loaded.
            if (sck_fall && skip_fall) begin
              skip_fall <= 1'b0;
            end else if (sck_fall) begin
              bit_cnt <= bit_cnt + 5'd1;
              shreg   <= {shreg[6:0], 1'b0};
              if (bit_cnt == 5'd7) begin
                bit_cnt  <= '0;
                byte_ptr <= byte_ptr + 2'd1;
                if (byte_ptr == 2'd3) begin
                  word     <= nxt_word;
                  shreg    <= word_byte(nxt_word, 2'd0);
                  mem_en   <= 1'b1;
                  mem_addr <= mem_addr + MEM_AW'(1);
                end else begin
                  shreg <= word_byte(word, byte_ptr + 2'd1);
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_miso = (state == DATA) ? shreg[7] : 1'b1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      half_cnt  <= '0;
      edge_seen <= 1'b0;
    end else if (sck_rise || sck_fall) begin
      half_cnt  <= '0;
      edge_seen <= 1'b1;
    end else if (half_cnt != 8'hFF) begin
      half_cnt <= half_cnt + 8'd1;
    end
  end

  a_half_period: assert property (@(posedge clock) disable iff (reset)
    ((sck_rise || sck_fall) && edge_seen && !ss_q) |-> (int'(half_cnt) >= MIN_HALF - 1));

  a_mem_en_spacing: assert property (@(posedge clock) disable iff (reset)
    !(mem_en && rd_vld));

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench for spi_flash_responder: bit-banged SPI master, word memory and
// a byte-stream reference model of the READ command.
module tb_spi_flash_responder;

  logic        clock;
  logic        reset;
  logic        spi_sck;
  logic        spi_ss_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        mem_en;
  logic [21:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        cmd_err;

  int vectors     = 0;
  int miscompares = 0;

  spi_flash_responder dut (
    .clock    (clock),
    .reset    (reset),
    .spi_sck  (spi_sck),
    .spi_ss_n (spi_ss_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem_init [logic [21:0]];

  function automatic logic [31:0] mem_word(input logic [21:0] wa);
    if (mem_init.exists(wa)) return mem_init[wa];
    return {wa[9:0], wa} ^ 32'hA5C3_0F1E;
  endfunction

  logic [21:0] memq [$];
  int          err_cnt = 0;
  int          consec  = 0;
  logic        mem_en_q = 1'b0;

  always @(posedge clock) begin
    if (mem_en) mem_rdata <= mem_word(mem_addr);
  end

  always @(posedge clock) begin
    if (mem_en) memq.push_back(mem_addr);
    if (cmd_err) err_cnt++;
    if (mem_en && mem_en_q) consec++;
    mem_en_q = mem_en;
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One SPI mode-0 bit; MISO is sampled at the end of the low half, just before the rise.
  task automatic sck_bit(input logic b, input int h, input logic last, output logic m);
    spi_mosi = b;
    repeat (h) tick();
    m = spi_miso;
    spi_sck = 1'b1;
    repeat (h) tick();
    spi_sck = 1'b0;
    if (last) spi_ss_n = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [23:0] a, input int nbits, input int h);
    logic [95:0] tx, rx, ex;
    logic        m;
    logic [23:0] ba;
    logic [31:0] w;
    logic [7:0]  by;
    int          shifts, nw;
    tx = {cmd, a, 64'h0};
    rx = '1;
    ex = '1;
    memq.delete();
    err_cnt = 0;
    consec  = 0;
    spi_ss_n = 1'b0;
    repeat (h) tick();
    for (int i = 0; i < nbits; i++) begin
      sck_bit(tx[95-i], h, (i == nbits - 1), m);
      rx[95-i] = m;
    end
    repeat (6) tick();

    // Reference: byte k of the stream is flash byte (a + k) mod 2^24, MSB first.
    if (cmd == 8'h03) begin
      for (int i = 32; i < nbits; i++) begin
        ba = a + 24'((i - 32) / 8);
        w  = mem_word(ba[23:2]);
        by = w[8*ba[1:0] +: 8];
        ex[95-i] = by[7 - ((i - 32) % 8)];
      end
    end
    check("miso_stream", rx, ex);

    // Initial fetch plus prefetch, then one more word each time a word's last byte is fully shifted.
    // The final fall coincides with SS rising and is not counted.
    nw = 0;
    if (cmd == 8'h03 && nbits >= 32) begin
      shifts = (nbits > 33) ? nbits - 33 : 0;
      nw = 2;
      for (int j = 0; 8 * (j + 1) <= shifts; j++) begin
        ba = a + 24'(j);
        if (ba[1:0] == 2'd3) nw++;
      end
    end
    check("mem_en_count", 96'(memq.size()), 96'(nw));
    for (int k = 0; k < nw && k < memq.size(); k++)
      check("mem_addr", 96'(memq[k]), 96'(22'(a[23:2] + 22'(k))));
    check("cmd_err_count", 96'(err_cnt), 96'((cmd != 8'h03 && nbits >= 8) ? 1 : 0));
    check("busy_after", 96'(busy), 96'(0));
    check("mem_en_b2b", 96'(consec), 96'(0));
    repeat (4) tick();
  endtask

  initial begin
    logic        m;
    logic [7:0]  rcmd;
    logic [23:0] raddr;
    int          rbits, rh;
    logic [31:0] rtx;

    reset     = 1'b1;
    spi_sck   = 1'b0;
    spi_ss_n  = 1'b1;
    spi_mosi  = 1'b0;
    mem_rdata = '0;
    mem_init[22'h000000] = $urandom;
    mem_init[22'h000001] = 32'h1234_5678;
    mem_init[22'h000002] = 32'hAABB_CCDD;
    mem_init[22'h3FFFFF] = $urandom;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("reset_miso",     96'(spi_miso), 96'(1));
    check("reset_busy",     96'(busy),     96'(0));
    check("reset_mem_en",   96'(mem_en),   96'(0));
    check("reset_cmd_err",  96'(cmd_err),  96'(0));
    check("reset_mem_addr", 96'(mem_addr), 96'(0));

    memq.delete();
    for (int i = 0; i < 4; i++) sck_bit(1'b1, 5, 1'b0, m);
    repeat (6) tick();
    check("ss_high_busy",   96'(busy),        96'(0));
    check("ss_high_mem_en", 96'(memq.size()), 96'(0));
    check("ss_high_miso",   96'(spi_miso),    96'(1));

    xfer(8'h03, 24'h000004, 64, 5);
    xfer(8'h03, 24'h000006, 64, 5);
    xfer(8'h9F, 24'h000000, 64, 5);
    xfer(8'h03, 24'h000000, 20, 5);
    xfer(8'h03, 24'h000000, 64, 5);
    xfer(8'h03, 24'hFFFFFC, 96, 6);

    // Reset during a transfer: the rest of that transfer must be ignored.
    spi_ss_n = 1'b0;
    rtx = {8'h03, 24'h000004};
    repeat (5) tick();
    for (int i = 0; i < 10; i++) sck_bit(rtx[31-i], 5, 1'b0, m);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("midreset_busy", 96'(busy), 96'(0));
    memq.delete();
    for (int i = 10; i < 40; i++) sck_bit((i < 32) ? rtx[31-i] : 1'b0, 5, (i == 39), m);
    repeat (6) tick();
    check("midreset_idle",   96'(busy),        96'(0));
    check("midreset_mem_en", 96'(memq.size()), 96'(0));
    repeat (4) tick();
    xfer(8'h03, 24'h000005, 48, 5);

    for (int t = 0; t < 16; t++) begin
      rcmd  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h03;
      raddr = ($urandom_range(0, 3) == 0) ? (24'hFFFFF0 | 24'($urandom_range(0, 15))) : 24'($urandom);
      rbits = $urandom_range(8, 96);
      rh    = $urandom_range(5, 7);
      xfer(rcmd, raddr, rbits, rh);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
